stopwatch_core: RTL

Minutes:seconds stopwatch that consumes the four divided square-wave clocks (1 Hz, 2 Hz, fast scan, blink) from the upstream clock divider. It treats those clocks as data, not as clocks: it synchronizes them into sys_clk and edge-detects them into single-cycle ticks. It counts time, supports pause and per-field adjust, and drives a 4-digit multiplexed active-low 7-segment display. Everything runs in the sys_clk domain.

---
 rtl/stopwatch_pkg.sv | 43 ++++
 rtl/stopwatch_core_tick_sync.sv | 44 ++++
 rtl/stopwatch_core.sv | 122 ++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the minutes:seconds stopwatch: wrap limit, active-low
// 7-segment digit codes and one-hot active-low anode patterns.
package stopwatch_pkg;

  localparam int MAX_VAL = 59;

  // Segment order is {g,f,e,d,c,b,a}, a lit segment is 0
  localparam logic [6:0] SEG_D0    = 7'b1000000;
  localparam logic [6:0] SEG_D1    = 7'b1111001;
  localparam logic [6:0] SEG_D2    = 7'b0100100;
  localparam logic [6:0] SEG_D3    = 7'b0110000;
  localparam logic [6:0] SEG_D4    = 7'b0011001;
  localparam logic [6:0] SEG_D5    = 7'b0010010;
  localparam logic [6:0] SEG_D6    = 7'b0000010;
  localparam logic [6:0] SEG_D7    = 7'b1111000;
  localparam logic [6:0] SEG_D8    = 7'b0000000;
  localparam logic [6:0] SEG_D9    = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_D0;
      4'd1:    code = SEG_D1;
      4'd2:    code = SEG_D2;
      4'd3:    code = SEG_D3;
      4'd4:    code = SEG_D4;
      4'd5:    code = SEG_D5;
      4'd6:    code = SEG_D6;
      4'd7:    code = SEG_D7;
      4'd8:    code = SEG_D8;
      4'd9:    code = SEG_D9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/stopwatch_core_tick_sync.sv
// Brings a slow square wave into the sys_clk domain as data and produces a
// one-cycle rising-edge pulse plus the synchronized level.
module tick_sync #(
  parameter int STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic din,
  output logic pulse,
  output logic level
);

  logic [STAGES-1:0] sync_reg;
  logic [STAGES-1:0] vld_reg;
  logic              prev_reg;
  logic              prev_vld_reg;
  logic              pulse_reg;

  // vld_reg tracks when the chain holds real samples; an input already high
  // out of reset is then taken as the starting level, not as an edge.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync_reg     <= '0;
      vld_reg      <= '0;
      prev_reg     <= 1'b0;
      prev_vld_reg <= 1'b0;
      pulse_reg    <= 1'b0;
    end else begin
      sync_reg[0] <= din;
      vld_reg[0]  <= 1'b1;
      for (int i = 1; i < STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
        vld_reg[i]  <= vld_reg[i-1];
      end
      prev_reg     <= sync_reg[STAGES-1];
      prev_vld_reg <= vld_reg[STAGES-1];
      pulse_reg    <= sync_reg[STAGES-1] & ~prev_reg & prev_vld_reg;
    end
  end

  assign pulse = pulse_reg;
  assign level = sync_reg[STAGES-1];

endmodule

// File: rtl/stopwatch_core.sv
// Minutes:seconds stopwatch with pause, per-field adjust and a 4-digit
// multiplexed active-low 7-segment display, all in the sys_clk domain.
module stopwatch_core #(
  parameter int MAX_VAL     = stopwatch_pkg::MAX_VAL,
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       onehz_clk,
  input  logic       twohz_clk,
  input  logic       faster_clk,
  input  logic       blinker_clk,
  input  logic       pause_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [3:0] an,
  output logic [6:0] seg
);

  import stopwatch_pkg::*;

  localparam logic [5:0] LIMIT = 6'(MAX_VAL);

  logic [3:0] raw_vec;
  logic [3:0] pulse_vec;
  logic [3:0] level_vec;
  logic       one_tick, two_tick, fast_tick, blink_lvl;
  logic       unused_taps;

  assign raw_vec = {blinker_clk, faster_clk, twohz_clk, onehz_clk};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      tick_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .sys_clk(sys_clk),
        .rst    (rst),
        .din    (raw_vec[gi]),
        .pulse  (pulse_vec[gi]),
        .level  (level_vec[gi])
      );
    end
  endgenerate

  assign one_tick    = pulse_vec[0];
  assign two_tick    = pulse_vec[1];
  assign fast_tick   = pulse_vec[2];
  assign blink_lvl   = level_vec[3];
  assign unused_taps = &{level_vec[2:0], pulse_vec[3]};

  logic [5:0] min_reg, min_next;
  logic [5:0] sec_reg, sec_next;
  logic       paused_reg;
  logic [1:0] scan_reg;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v);
    return (v >= LIMIT) ? 6'd0 : v + 6'd1;
  endfunction

  // Adjust has priority over counting, so one_tick is dropped while adj=1
  always_comb begin
    min_next = min_reg;
    sec_next = sec_reg;
    if (adj) begin
      if (two_tick) begin
        if (sel) sec_next = wrap_inc(sec_reg);
        else     min_next = wrap_inc(min_reg);
      end
    end else if (one_tick && !paused_reg) begin
      sec_next = wrap_inc(sec_reg);
      if (sec_reg >= LIMIT) min_next = wrap_inc(min_reg);
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      min_reg    <= '0;
      sec_reg    <= '0;
      paused_reg <= 1'b0;
      scan_reg   <= '0;
    end else begin
      min_reg <= min_next;
      sec_reg <= sec_next;
      if (pause_pulse) paused_reg <= ~paused_reg;
      if (fast_tick)   scan_reg   <= scan_reg + 2'd1;
    end
  end

  assign minutes = min_reg;
  assign seconds = sec_reg;

  logic [5:0] field_val;
  logic [3:0] tens, ones, digit;
  logic       blank;

  always_comb begin
    field_val = scan_reg[1] ? min_reg : sec_reg;
    tens      = 4'd0;
    if      (field_val >= 6'd60) tens = 4'd6;
    else if (field_val >= 6'd50) tens = 4'd5;
    else if (field_val >= 6'd40) tens = 4'd4;
    else if (field_val >= 6'd30) tens = 4'd3;
    else if (field_val >= 6'd20) tens = 4'd2;
    else if (field_val >= 6'd10) tens = 4'd1;
    ones  = 4'(field_val - 6'(tens) * 6'd10);
    digit = scan_reg[0] ? tens : ones;
    // Blank the field being adjusted: minutes when sel=0, seconds when sel=1
    blank = adj && blink_lvl && (scan_reg[1] != sel);
    seg   = blank ? SEG_BLANK : seg_encode(digit);
  end

  always_comb begin
    case (scan_reg)
      2'd0:    an = AN_DIG0;
      2'd1:    an = AN_DIG1;
      2'd2:    an = AN_DIG2;
      default: an = AN_DIG3;
    endcase
  end

endmodule
